int_gen: RTL and testbench

Interrupt-generator responder for the `m_int_addr` / `m_int_byteen` acknowledge port of the MIPS top.
- Drives the external `interrupt` line, which becomes HWInt[2] in the processor, on a programmed schedule.
- Withdraws the request when the processor's interrupt handler stores to the acknowledge address through the bridge.
- Sits beside the top in the system bench and replaces ad-hoc testbench interrupt logic with a checked, cycle-exact source.

---
 rtl/int_gen_pkg.sv | 26 ++
 rtl/int_gen_cnt.sv | 23 ++
 rtl/int_gen.sv | 139 +++++++++++++
 tb/tb_int_gen.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/int_gen_pkg.sv
// Shared definitions for the interrupt-generator responder: FSM states,
// trigger-mode encodings, default acknowledge address and ack decode.
package int_gen_pkg;

  typedef enum logic [2:0] {
    IG_IDLE    = 3'd0,
    IG_ARMED   = 3'd1,
    IG_DELAY   = 3'd2,
    IG_ASSERT  = 3'd3,
    IG_HOLDOFF = 3'd4,
    IG_DONE    = 3'd5
  } ig_state_t;

  localparam logic IG_MODE_PC       = 1'b0;
  localparam logic IG_MODE_PERIODIC = 1'b1;

  localparam logic [31:0] IG_ACK_ADDR = 32'h0000_7F20;

  // Word-granular match: byte offset bits are ignored, any byte lane counts.
  function automatic logic ig_is_ack(input logic [31:0] addr,
                                     input logic [3:0]  byteen,
                                     input logic [31:0] ack_addr);
    return (addr[31:2] == ack_addr[31:2]) && (|byteen);
  endfunction

endpackage

// File: rtl/int_gen_cnt.sv
// Loadable 32-bit up/down counter with zero flag, shared by every timed
// state of int_gen. Load has priority over up, up over down.
module int_gen_cnt (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] load_value,
  input  logic        up,
  input  logic        down,
  output logic [31:0] count,
  output logic        zero
);

  always_ff @(posedge clk) begin
    if (reset)     count <= '0;
    else if (load) count <= load_value;
    else if (up)   count <= count + 32'd1;
    else if (down) count <= count - 32'd1;
  end

  assign zero = (count == '0);

endmodule

// File: rtl/int_gen.sv
// Interrupt generator: raises `interrupt` on a PC match or a periodic
// schedule and withdraws it when the handler stores to the ack address.
module int_gen
  import int_gen_pkg::*;
#(
  parameter logic [31:0] ACK_ADDR   = IG_ACK_ADDR,
  parameter logic [31:0] TRIGGER_PC = 32'h0000_3010,
  parameter logic [31:0] DELAY      = 32'd0,
  parameter logic [31:0] PERIOD     = 32'd100,
  parameter logic [31:0] HOLDOFF    = 32'd4,
  parameter logic [31:0] MAX_IRQ    = 32'd1,
  parameter logic [31:0] TIMEOUT    = 32'd1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        mode,
  input  logic [31:0] macroscopic_pc,
  input  logic [31:0] int_addr,
  input  logic [3:0]  int_byteen,
  output logic        interrupt,
  output logic [7:0]  irq_count,
  output logic        busy,
  output logic        spurious_ack,
  output logic        timeout
);

  ig_state_t   state, state_next;
  logic        mode_q;
  logic        ack, pc_match;
  logic        cnt_load, cnt_up, cnt_down, cnt_zero;
  logic [31:0] cnt_value, cnt;
  logic        count_inc, set_timeout;
  logic [7:0]  irq_next;

  assign ack      = ig_is_ack(int_addr, int_byteen, ACK_ADDR);
  assign pc_match = (macroscopic_pc == TRIGGER_PC);
  assign irq_next = irq_count + 8'd1;

  int_gen_cnt u_cnt (
    .clk        (clk),
    .reset      (reset),
    .load       (cnt_load),
    .load_value (cnt_value),
    .up         (cnt_up),
    .down       (cnt_down),
    .count      (cnt),
    .zero       (cnt_zero)
  );

  always_comb begin
    state_next  = state;
    cnt_load    = 1'b0;
    cnt_value   = '0;
    cnt_up      = 1'b0;
    cnt_down    = 1'b0;
    count_inc   = 1'b0;
    set_timeout = 1'b0;
    case (state)
      IG_IDLE: begin
        if (enable) begin
          state_next = IG_ARMED;
          cnt_load   = (mode == IG_MODE_PERIODIC);
          cnt_value  = PERIOD;
        end
      end
      IG_ARMED: begin
        if (mode_q == IG_MODE_PC) begin
          if (pc_match) begin
            state_next = IG_DELAY;
            cnt_load   = 1'b1;
            cnt_value  = DELAY;
          end
        end else if (cnt_zero) begin
          state_next = IG_ASSERT;
          cnt_load   = 1'b1;
        end else begin
          cnt_down = 1'b1;
        end
      end
      IG_DELAY: begin
        if (cnt_zero) begin
          state_next = IG_ASSERT;
          cnt_load   = 1'b1;
        end else begin
          cnt_down = 1'b1;
        end
      end
      IG_ASSERT: begin
        if (ack) begin
          count_inc = 1'b1;
          if (MAX_IRQ != '0 && {24'd0, irq_next} == MAX_IRQ) begin
            state_next = IG_DONE;
          end else begin
            state_next = IG_HOLDOFF;
            cnt_load   = 1'b1;
            cnt_value  = HOLDOFF;
          end
        end else begin
          // cnt holds completed ASSERT cycles; this edge completes one more
          cnt_up      = 1'b1;
          set_timeout = (TIMEOUT != '0) && (cnt + 32'd1 == TIMEOUT);
        end
      end
      IG_HOLDOFF: begin
        if (cnt_zero) begin
          state_next = IG_ARMED;
          cnt_load   = (mode_q == IG_MODE_PERIODIC);
          cnt_value  = PERIOD;
        end else begin
          cnt_down = 1'b1;
        end
      end
      IG_DONE: state_next = IG_DONE;
      default: state_next = IG_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IG_IDLE;
      mode_q       <= IG_MODE_PC;
      interrupt    <= 1'b0;
      irq_count    <= '0;
      spurious_ack <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      state     <= state_next;
      interrupt <= (state_next == IG_ASSERT);
      if (state == IG_IDLE && enable) mode_q <= mode;
      if (count_inc) irq_count <= irq_next;
      if (ack && state != IG_ASSERT) spurious_ack <= 1'b1;
      if (set_timeout) timeout <= 1'b1;
    end
  end

  assign busy = state inside {IG_ARMED, IG_DELAY, IG_ASSERT, IG_HOLDOFF};

endmodule

// File: tb/tb_int_gen.sv
// Self-checking bench for int_gen: deadline-based behavioural model compared
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_int_gen;

  localparam logic [31:0] T_ACK  = 32'h0000_7F20;
  localparam logic [31:0] T_TRIG = 32'h0000_3010;
  localparam int T_DELAY   = 0;
  localparam int T_PERIOD  = 5;
  localparam int T_HOLDOFF = 2;
  localparam int T_MAX     = 3;
  localparam int T_TMO     = 10;

  logic        clk = 1'b0;
  logic        reset, enable, mode;
  logic [31:0] macroscopic_pc, int_addr;
  logic [3:0]  int_byteen;
  logic        interrupt, busy, spurious_ack, timeout;
  logic [7:0]  irq_count;

  int_gen #(
    .ACK_ADDR   (T_ACK),
    .TRIGGER_PC (T_TRIG),
    .DELAY      (32'(T_DELAY)),
    .PERIOD     (32'(T_PERIOD)),
    .HOLDOFF    (32'(T_HOLDOFF)),
    .MAX_IRQ    (32'(T_MAX)),
    .TIMEOUT    (32'(T_TMO))
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .mode           (mode),
    .macroscopic_pc (macroscopic_pc),
    .int_addr       (int_addr),
    .int_byteen     (int_byteen),
    .interrupt      (interrupt),
    .irq_count      (irq_count),
    .busy           (busy),
    .spurious_ack   (spurious_ack),
    .timeout        (timeout)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: phases with absolute deadlines instead of counters.
  localparam int M_IDLE = 0, M_WAIT_PC = 1, M_COUNTDOWN = 2, M_HIGH = 3, M_QUIET = 4, M_FINISHED = 5;
  int     m_phase = M_IDLE;
  longint cyc = 0, due = 0, since = 0;
  int     m_cnt = 0;
  bit     m_periodic = 0, m_spur = 0, m_tmo = 0, m_valid = 0, m_ack = 0;

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      m_phase = M_IDLE; m_cnt = 0; m_spur = 0; m_tmo = 0; m_valid = 1;
    end else if (m_valid) begin
      m_ack = ((int_addr & 32'hFFFF_FFFC) == T_ACK) && (int_byteen != 4'h0);
      if (m_ack && m_phase != M_HIGH) m_spur = 1;
      case (m_phase)
        M_IDLE: if (enable) begin
          m_periodic = mode;
          if (mode) begin m_phase = M_COUNTDOWN; due = cyc + T_PERIOD + 1; end
          else m_phase = M_WAIT_PC;
        end
        M_WAIT_PC: if (macroscopic_pc == T_TRIG) begin
          m_phase = M_COUNTDOWN; due = cyc + 1 + T_DELAY;
        end
        M_COUNTDOWN: if (cyc == due) begin m_phase = M_HIGH; since = cyc; end
        M_HIGH: begin
          if (m_ack) begin
            m_cnt++;
            if (T_MAX != 0 && m_cnt == T_MAX) m_phase = M_FINISHED;
            else begin m_phase = M_QUIET; due = cyc + 1 + T_HOLDOFF; end
          end else if (cyc - since == T_TMO) m_tmo = 1;
        end
        M_QUIET: if (cyc == due) begin
          if (m_periodic) begin m_phase = M_COUNTDOWN; due = cyc + T_PERIOD + 1; end
          else m_phase = M_WAIT_PC;
        end
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("m_interrupt", 32'(interrupt), 32'(m_phase == M_HIGH));
      check("m_busy", 32'(busy), 32'(m_phase >= M_WAIT_PC && m_phase <= M_QUIET));
      check("m_irq_count", 32'(irq_count), 32'(m_cnt % 256));
      check("m_spurious", 32'(spurious_ack), 32'(m_spur));
      check("m_timeout", 32'(timeout), 32'(m_tmo));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b0; int_addr = '0; int_byteen = '0;
    step(); step();
    reset = 1'b0;
  endtask

  task automatic do_ack(input logic [31:0] addr, input logic [3:0] be);
    int_addr = addr; int_byteen = be;
    step();
    int_addr = '0; int_byteen = '0;
  endtask

  task automatic wait_rise(input int limit, output int n);
    n = 0;
    while (interrupt !== 1'b1 && n < limit) begin step(); n++; end
    if (interrupt !== 1'b1) check("wait_rise_bound", 32'(interrupt), 32'd1);
  endtask

  int n, pulses;

  initial begin
    reset = 1'b1; enable = 1'b0; mode = 1'b0;
    macroscopic_pc = '0; int_addr = '0; int_byteen = '0;
    do_reset();
    check("rst_interrupt", 32'(interrupt), 32'd0);
    check("rst_irq_count", 32'(irq_count), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_spurious", 32'(spurious_ack), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);

    // PC mode, DELAY=0
    enable = 1'b1; mode = 1'b0; step(); enable = 1'b0;
    check("pc_armed_busy", 32'(busy), 32'd1);
    for (int r = 0; r < 3; r++) begin
      macroscopic_pc = 32'h3000; step();
      macroscopic_pc = 32'h300C; step();
      macroscopic_pc = 32'h3010; step();
      macroscopic_pc = 32'h3014;
      check("pc_not_yet", 32'(interrupt), 32'd0);
      step();
      check("pc_rise", 32'(interrupt), 32'd1);
      if (r == 0) begin
        do_ack(32'h7F20, 4'h0);
        check("ack_be0_ignored", 32'(interrupt), 32'd1);
        do_ack(32'h7F24, 4'hF);
        check("ack_7f24_ignored", 32'(interrupt), 32'd1);
        check("ack_bad_no_spur", 32'(spurious_ack), 32'd0);
      end
      if (r == 1) do_ack(32'h7F23, 4'h1);
      else        do_ack(32'h7F20, 4'hF);
      check("ack_withdraw", 32'(interrupt), 32'd0);
      check("ack_count", 32'(irq_count), 32'(r + 1));
      repeat (4) step();
    end
    check("pc_done_busy", 32'(busy), 32'd0);
    macroscopic_pc = 32'h3010;
    repeat (5) step();
    check("pc_done_no_irq", 32'(interrupt), 32'd0);
    check("pc_done_count", 32'(irq_count), 32'd3);
    macroscopic_pc = '0;

    // periodic mode
    do_reset();
    enable = 1'b1; mode = 1'b1; step(); enable = 1'b0;
    wait_rise(50, n);
    check("per_first_rise", 32'(n), 32'd6);
    for (int p = 0; p < 3; p++) begin
      step(); step();
      do_ack(32'h7F20, 4'hF);
      if (p < 2) begin
        wait_rise(50, n);
        check("per_gap", 32'(n + 3), 32'd12);
      end
    end
    pulses = 0;
    repeat (40) begin step(); if (interrupt) pulses++; end
    check("per_no_4th_pulse", 32'(pulses), 32'd0);
    check("per_end_count", 32'(irq_count), 32'd3);
    check("per_end_busy", 32'(busy), 32'd0);

    // ack in IDLE
    do_reset();
    do_ack(32'h7F20, 4'hF);
    check("idle_ack_spur", 32'(spurious_ack), 32'd1);
    check("idle_ack_irq", 32'(interrupt), 32'd0);

    // timeout, then reset mid-ASSERT
    do_reset();
    enable = 1'b1; mode = 1'b1; step(); enable = 1'b0;
    wait_rise(50, n);
    repeat (9) step();
    check("tmo_before", 32'(timeout), 32'd0);
    step();
    check("tmo_set", 32'(timeout), 32'd1);
    check("tmo_irq_high", 32'(interrupt), 32'd1);
    reset = 1'b1; step();
    check("rst2_interrupt", 32'(interrupt), 32'd0);
    check("rst2_timeout", 32'(timeout), 32'd0);
    check("rst2_busy", 32'(busy), 32'd0);
    check("rst2_spurious", 32'(spurious_ack), 32'd0);
    check("rst2_count", 32'(irq_count), 32'd0);
    reset = 1'b0; step();
    check("rst2_idle", 32'(busy), 32'd0);

    // ack and PC match in the same ARMED cycle
    do_reset();
    enable = 1'b1; mode = 1'b0; step(); enable = 1'b0; step();
    macroscopic_pc = 32'h3010; int_addr = 32'h7F20; int_byteen = 4'hF;
    step();
    macroscopic_pc = '0; int_addr = '0; int_byteen = '0;
    check("race_spur", 32'(spurious_ack), 32'd1);
    check("race_busy", 32'(busy), 32'd1);
    check("race_not_yet", 32'(interrupt), 32'd0);
    step();
    check("race_rise", 32'(interrupt), 32'd1);

    // random traffic against the model
    repeat (2500) begin
      reset  = ($urandom_range(199) == 0);
      enable = ($urandom_range(7) == 0);
      mode   = 1'($urandom_range(1));
      macroscopic_pc = ($urandom_range(3) == 0) ? T_TRIG : 32'h3000 + 32'(4 * $urandom_range(15));
      if ($urandom_range(5) == 0) begin
        case ($urandom_range(3))
          0: int_addr = 32'h7F20;
          1: int_addr = 32'h7F23;
          2: int_addr = 32'h7F24;
          default: int_addr = 32'h7F1C;
        endcase
      end else begin
        int_addr = 32'h1000;
      end
      int_byteen = 4'($urandom_range(15));
      step();
    end
    reset = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
